gate_serial_arbiter: RTL and testbench

- Shares one instance of the team's 1-bit two-input gate cell (AND/OR/NOT A/NOT B/NAND/NOR/XOR) between two requesters.
- Each requester submits a WIDTH-bit bitwise logic operation. The block arbitrates round-robin, then streams the operand bits LSB-first through the single gate cell, one bit per cycle.
- It assembles the WIDTH-bit result and returns it on a valid/ready response port.
- It sits between requester logic and the shared gate datapath, as its sequencer and arbiter.

---
 rtl/gate_serial_arbiter.sv | 148 ++++++++++++++
 tb/tb_gate_serial_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_serial_arbiter.sv
// Two-requester round-robin sequencer that shares one 1-bit gate cell, streaming
// WIDTH-bit bitwise operations LSB-first and returning the result on a valid/ready port.
module gate_serial_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             id_q, id_d;
    logic             err_q, err_d;
    logic             prio_q, prio_d;

    logic             grant_any;
    logic             grant_id;
    logic [2:0]       grant_op;
    logic             bit_a, bit_b;
    logic             gate_y;

    // The shared 1-bit gate cell; opcode 7 is illegal and yields 0.
    function automatic logic gate_cell(input logic [2:0] op, input logic a, input logic b);
        case (op)
            3'd0:    gate_cell = a & b;
            3'd1:    gate_cell = a | b;
            3'd2:    gate_cell = ~a;
            3'd3:    gate_cell = ~b;
            3'd4:    gate_cell = ~(a & b);
            3'd5:    gate_cell = ~(a | b);
            3'd6:    gate_cell = a ^ b;
            default: gate_cell = 1'b0;
        endcase
    endfunction

    // With both requesting, prio_q names the requester that goes first.
    always_comb begin
        grant_any = (state_q == IDLE) && (req0_valid || req1_valid);
        grant_id  = (req0_valid && req1_valid) ? prio_q : req1_valid;
        grant_op  = grant_id ? req1_op : req0_op;
    end

    assign req0_ready = grant_any && !grant_id;
    assign req1_ready = grant_any && grant_id;

    always_comb begin
        bit_a = 1'b0;
        bit_b = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                bit_a = a_q[i];
                bit_b = b_q[i];
            end
        end
    end

    assign gate_y = gate_cell(op_q, bit_a, bit_b);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        id_d     = id_q;
        err_d    = err_q;
        prio_d   = prio_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d  = BUSY;
                    cnt_d    = '0;
                    result_d = '0;
                    id_d     = grant_id;
                    prio_d   = ~grant_id;
                    op_d     = grant_op;
                    a_d      = grant_id ? req1_a : req0_a;
                    b_d      = grant_id ? req1_b : req0_b;
                    err_d    = (grant_op == 3'd7);
                end
            end
            BUSY: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CNT_W'(i)) result_d[i] = gate_y;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            id_q     <= 1'b0;
            err_q    <= 1'b0;
            prio_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            id_q     <= id_d;
            err_q    <= err_d;
            prio_q   <= prio_d;
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = result_q;
    assign rsp_id    = id_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_gate_serial_arbiter.sv
// Scoreboard bench for gate_serial_arbiter: a word-level reference model predicts grants,
// response timing and results; a negedge monitor compares everything the DUT presents.
module tb_gate_serial_arbiter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [W-1:0] rsp_data;

    gate_serial_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {logic [2:0] op; logic [W-1:0] a; logic [W-1:0] b;} op_t;
    typedef struct {logic id; logic [W-1:0] data; logic err;} exp_t;

    op_t  src0[$], src1[$];
    exp_t sb[$];

    int   checks = 0, failures = 0;
    int   cyc = 0;
    bit   m_out = 0, m_prio = 0, m_w, rchk = 0;
    int   m_due = 0;
    bit   hs0 = 0, hs1 = 0;
    bit   rnd_mode = 0;
    int   rr_mode = 0;  // 0: rsp_ready high, 1: random, 2: held low

    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return ~b;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input bit which, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        op_t t;
        t.op = op; t.a = a; t.b = b;
        if (which) src1.push_back(t);
        else       src0.push_back(t);
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while ((src0.size() != 0 || src1.size() != 0 || m_out) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", W'(n >= lim), '0);
        check("sb_empty", W'(sb.size()), '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Reference model: decides grants and response timing at each rising edge.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_out = 0; m_prio = 0; rchk = 1;
            sb.delete();
        end else begin
            rchk = 0;
            if (m_out) begin
                if (cyc >= m_due && rsp_ready) m_out = 0;
            end else if (req0_valid || req1_valid) begin
                exp_t e;
                m_w    = (req0_valid && req1_valid) ? m_prio : req1_valid;
                e.id   = m_w;
                e.err  = ((m_w ? req1_op : req0_op) == 3'd7);
                e.data = m_w ? ref_op(req1_op, req1_a, req1_b) : ref_op(req0_op, req0_a, req0_b);
                sb.push_back(e);
                m_prio = !m_w;
                m_out  = 1;
                m_due  = cyc + W + 1;
            end
        end
        cyc++;
    end

    // Monitor: compares DUT outputs mid-cycle against the model.
    initial forever begin
        bit exp_v, exp_r0, exp_r1;
        @(negedge clk);
        if (cyc > 0) begin
            exp_v  = m_out && (cyc >= m_due);
            exp_r0 = !m_out && req0_valid && (!req1_valid || !m_prio);
            exp_r1 = !m_out && req1_valid && (!req0_valid || m_prio);
            check("req0_ready", W'(req0_ready), W'(exp_r0));
            check("req1_ready", W'(req1_ready), W'(exp_r1));
            check("rsp_valid", W'(rsp_valid), W'(exp_v));
            check("busy", W'(busy), W'(m_out));
            if (rchk) begin
                check("reset_rsp_data", rsp_data, '0);
                check("reset_rsp_id", W'(rsp_id), '0);
                check("reset_rsp_err", W'(rsp_err), '0);
            end
            if (exp_v && sb.size() != 0) begin
                check("rsp_data", rsp_data, sb[0].data);
                check("rsp_id", W'(rsp_id), W'(sb[0].id));
                check("rsp_err", W'(rsp_err), W'(sb[0].err));
                if (rsp_ready) void'(sb.pop_front());
            end
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
        end
    end

    // Driver: presents queued operations; operands turn to junk once accepted.
    initial begin
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        forever begin
            @(posedge clk); #1;
            if (hs0 && src0.size() != 0) void'(src0.pop_front());
            if (hs1 && src1.size() != 0) void'(src1.pop_front());
            hs0 = 0; hs1 = 0;
            if (src0.size() != 0 && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
                req0_valid = 1; req0_op = src0[0].op; req0_a = src0[0].a; req0_b = src0[0].b;
            end else begin
                req0_valid = 0; req0_op = 3'($urandom); req0_a = W'($urandom); req0_b = W'($urandom);
            end
            if (src1.size() != 0 && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
                req1_valid = 1; req1_op = src1[0].op; req1_a = src1[0].a; req1_b = src1[0].b;
            end else begin
                req1_valid = 0; req1_op = 3'($urandom); req1_a = W'($urandom); req1_b = W'($urandom);
            end
            case (rr_mode)
                0:       rsp_ready = 1;
                1:       rsp_ready = ($urandom_range(0, 2) != 0);
                default: rsp_ready = 0;
            endcase
        end
    end

    initial begin
        int n;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        push(0, 3'd0, 8'hF0, 8'h3C);
        drain(100);

        push(1, 3'd6, 8'hA5, 8'h0F);
        push(1, 3'd4, 8'hFF, 8'h0F);
        drain(100);

        do_reset();
        push(0, 3'd1, 8'h12, 8'h40); push(0, 3'd5, 8'h0F, 8'h30);
        push(1, 3'd3, 8'h00, 8'h81); push(1, 3'd0, 8'hCC, 8'hAA);
        drain(200);

        push(0, 3'd7, 8'hFF, 8'hFF);
        drain(100);

        rr_mode = 2;
        push(0, 3'd2, 8'h5A, 8'h00);
        push(0, 3'd6, 8'h33, 8'h55);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("stall_wait_timeout", W'(n >= 50), '0);
        repeat (2) @(negedge clk);
        rr_mode = 0;
        drain(100);

        push(0, 3'd1, 8'h0F, 8'hF0);
        n = 0;
        while (!(req0_valid && req0_ready) && n < 50) begin @(negedge clk); n++; end
        check("grant_wait_timeout", W'(n >= 50), '0);
        repeat (5) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        push(1, 3'd6, 8'hFF, 8'h01);
        push(0, 3'd4, 8'h3C, 8'hC3);
        drain(100);

        rnd_mode = 1;
        rr_mode  = 1;
        for (int i = 0; i < 20; i++) begin
            push(0, 3'($urandom), W'($urandom), W'($urandom));
            push(1, 3'($urandom), W'($urandom), W'($urandom));
        end
        drain(4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
